// File: rtl/ysyx_23060096_rf_wb_sched_if.sv
// Bundle of issue, writeback and RF write port signals around the writeback scheduler.
interface ysyx_23060096_rf_wb_sched_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);

   // IDU issue
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_rs1;
   logic [ADDR_WIDTH-1:0] issue_rs2;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  issue_ready;

   // EXU writeback request
   logic                  exu_valid;
   logic [ADDR_WIDTH-1:0] exu_rd;
   logic [DATA_WIDTH-1:0] exu_data;
   logic                  exu_ready;

   // LSU writeback request
   logic                  lsu_valid;
   logic [ADDR_WIDTH-1:0] lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;
   logic                  lsu_ready;

   // RF write port and error flag
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  wb_err;

   // Pipeline side: presents issue and writeback requests, consumes RF writes
   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd,
      input  issue_ready,
      output exu_valid, exu_rd, exu_data,
      input  exu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rf_wen, rf_waddr, rf_wdata, wb_err
   );

   // Scheduler side
   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd,
      output issue_ready,
      input  exu_valid, exu_rd, exu_data,
      output exu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rf_wen, rf_waddr, rf_wdata, wb_err
   );

endinterface

// File: rtl/ysyx_23060096_rf_wb_sched.sv
// RF write-port scheduler and busy-register scoreboard: arbitrates EXU/LSU
// writeback onto the single RF write port and stalls issue on RAW/WAW hazards.
module ysyx_23060096_rf_wb_sched #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic                         clk,
   input logic                         rstn,
   ysyx_23060096_rf_wb_sched_if.slave  bus
);

   localparam int unsigned NREG = 32'(1) << ADDR_WIDTH;

   typedef enum logic {
      GRANT_EXU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_nxt;
   grant_e                last_grant;

   logic                  rs1_busy_c;
   logic                  rs2_busy_c;
   logic                  rd_busy_c;
   logic                  issue_ready_c;
   logic                  issue_fire_c;
   logic                  grant_exu_c;
   logic                  grant_lsu_c;
   logic                  wb_fire_c;
   logic [ADDR_WIDTH-1:0] wb_rd_c;
   logic [DATA_WIDTH-1:0] wb_data_c;
   logic                  wb_unexpected_c;

   // Hazard detection against the scoreboard; x0 is never a hazard
   always_comb begin
      rs1_busy_c    = busy[bus.issue_rs1] & (bus.issue_rs1 != '0);
      rs2_busy_c    = busy[bus.issue_rs2] & (bus.issue_rs2 != '0);
      rd_busy_c     = busy[bus.issue_rd]  & (bus.issue_rd  != '0);
      issue_ready_c = ~(rs1_busy_c | rs2_busy_c | rd_busy_c);
      issue_fire_c  = bus.issue_valid & issue_ready_c;
   end

   // Round-robin grant: a lone requester wins, on contention the last loser wins
   always_comb begin
      grant_exu_c = bus.exu_valid & (~bus.lsu_valid | (last_grant == GRANT_LSU));
      grant_lsu_c = bus.lsu_valid & (~bus.exu_valid | (last_grant == GRANT_EXU));
      wb_fire_c   = grant_exu_c | grant_lsu_c;
      wb_rd_c     = grant_lsu_c ? bus.lsu_rd   : bus.exu_rd;
      wb_data_c   = grant_lsu_c ? bus.lsu_data : bus.exu_data;
      wb_unexpected_c = wb_fire_c & (wb_rd_c != '0) & ~busy[wb_rd_c];
   end

   assign bus.issue_ready = issue_ready_c;
   assign bus.exu_ready   = grant_exu_c;
   assign bus.lsu_ready   = grant_lsu_c;

   // Next scoreboard: writeback clears its rd, accepted issue marks its rd
   always_comb begin
      busy_nxt = busy;
      if (wb_fire_c) begin
         busy_nxt[wb_rd_c] = 1'b0;
      end
      if (issue_fire_c && (bus.issue_rd != '0)) begin
         busy_nxt[bus.issue_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard and arbitration history
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy       <= '0;
         last_grant <= GRANT_EXU;
      end else begin
         busy <= busy_nxt;
         if (bus.exu_valid && bus.lsu_valid) begin
            last_grant <= grant_lsu_c ? GRANT_LSU : GRANT_EXU;
         end
      end
   end

   // Registered RF write port; address/data hold when nothing is granted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.rf_wen   <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
      end else begin
         bus.rf_wen <= wb_fire_c & (wb_rd_c != '0);
         if (wb_fire_c) begin
            bus.rf_waddr <= wb_rd_c;
            bus.rf_wdata <= wb_data_c;
         end
      end
   end

   // Sticky flag for writebacks that no issued instruction was waiting on
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.wb_err <= 1'b0;
      end else if (wb_unexpected_c) begin
         bus.wb_err <= 1'b1;
      end
   end

endmodule
